// File: rtl/mfp_uart_hex_loader_pkg.sv
// Shared definitions for the UART hex loader: ASCII codes, FSM encodings,
// error bit positions and small character-classification helpers.
package mfp_uart_hex_loader_pkg;

    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_SYNTAX  = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [2:0] {
        P_IDLE,
        P_ADDR,
        P_DATA,
        P_SLASH,
        P_COMMENT,
        P_EMIT
    } parser_state_e;

    // Oversampling divider: round(clk / (16 * baud)), never below 1.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = (clk_freq + baud * 8) / (baud * 16);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters have low nibble 1..6 for both cases, so add 9 to reach 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [3:0] v;
        if (c <= 8'h39) begin
            v = c[3:0];
        end else begin
            v = c[3:0] + 4'd9;
        end
        return v;
    endfunction

    function automatic logic is_space(input logic [7:0] c);
        return (c == CH_SP) || (c == CH_TAB) || (c == CH_CR) || (c == CH_LF);
    endfunction

endpackage

// File: rtl/mfp_uart_hex_loader_receiver.sv
// 8N1 UART receiver with 16x oversampling. Emits a one-cycle strobe per good
// character and a one-cycle pulse per framing error.
module mfp_uart_receiver
    import mfp_uart_hex_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       SI_ClkIn,
    input  logic       SI_Reset,
    input  logic       UART_RX,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             meta_q, sync_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             strobe_q, strobe_d;
    logic             ferr_q, ferr_d;
    logic             tick_s;

    assign tick_s       = (div_q == DIV_W'(DIV - 1));
    assign rx_byte      = byte_q;
    assign rx_strobe    = strobe_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != RX_IDLE);

    // Synchronizer and edge-history flops; the idle line level is high.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= UART_RX;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            state_q  <= RX_IDLE;
            div_q    <= '0;
            tcnt_q   <= 4'd0;
            bcnt_q   <= 3'd0;
            shift_q  <= 8'h00;
            byte_q   <= 8'h00;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state logic: sample mid start bit, then every 16 ticks.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                    div_d   = '0;
                    tcnt_d  = 4'd0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick_s) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d = 4'd0;
                        bcnt_d = 3'd0;
                        if (sync_q) begin
                            state_d = RX_IDLE;
                        end else begin
                            state_d = RX_DATA;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            RX_DATA: begin
                if (tick_s) begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d  = 4'd0;
                        shift_d = {sync_q, shift_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = RX_STOP;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            RX_STOP: begin
                if (tick_s) begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d = 4'd0;
                        if (sync_q) begin
                            byte_d   = shift_q;
                            strobe_d = 1'b1;
                            state_d  = RX_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = RX_WAIT_HIGH;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mfp_uart_hex_loader.sv
// Hex-stream program loader: UART receiver, one-entry character buffer,
// token parser and auto-incrementing write address.
module mfp_uart_hex_loader
    import mfp_uart_hex_loader_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset,
    input  logic                  UART_RX,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_byte,
    output logic                  busy,
    output logic [2:0]            error
);

    localparam int               CNT_W   = $clog2(ADDR_WIDTH / 4 + 2);
    localparam logic [CNT_W-1:0] MAX_DIG = CNT_W'(ADDR_WIDTH / 4);

    logic [7:0]            rx_byte_s;
    logic                  rx_strobe_s, rx_frame_err_s, rx_busy_s;
    logic                  hold_valid_q, hold_valid_d;
    logic [7:0]            hold_byte_q, hold_byte_d;
    parser_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      dcnt_q, dcnt_d;
    logic                  skip_q, skip_d;
    logic [7:0]            data_q, data_d;
    logic [2:0]            err_q, err_d;
    logic                  consume_s;
    logic [7:0]            ch_s;

    mfp_uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .SI_ClkIn     (SI_ClkIn),
        .SI_Reset     (SI_Reset),
        .UART_RX      (UART_RX),
        .rx_byte      (rx_byte_s),
        .rx_strobe    (rx_strobe_s),
        .rx_frame_err (rx_frame_err_s),
        .rx_busy      (rx_busy_s)
    );

    assign ch_s      = hold_byte_q;
    assign consume_s = hold_valid_q && (state_q != P_EMIT);
    assign wr_valid  = (state_q == P_EMIT);
    assign wr_addr   = addr_q;
    assign wr_byte   = data_q;
    assign busy      = rx_busy_s || hold_valid_q || (state_q != P_IDLE);
    assign error     = err_q;

    // Buffer, parser and address registers.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            hold_valid_q <= 1'b0;
            hold_byte_q  <= 8'h00;
            state_q      <= P_IDLE;
            acc_q        <= '0;
            addr_q       <= '0;
            dcnt_q       <= '0;
            skip_q       <= 1'b0;
            data_q       <= 8'h00;
            err_q        <= 3'b000;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_byte_q  <= hold_byte_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            addr_q       <= addr_d;
            dcnt_q       <= dcnt_d;
            skip_q       <= skip_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    // Holding register fill/drain, sticky errors and parser next state.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_byte_d  = hold_byte_q;
        state_d      = state_q;
        acc_d        = acc_q;
        addr_d       = addr_q;
        dcnt_d       = dcnt_q;
        skip_d       = skip_q;
        data_d       = data_q;
        err_d        = err_q;

        // A strobe may refill the slot in the same cycle it is consumed.
        if (rx_strobe_s) begin
            if (!hold_valid_q || consume_s) begin
                hold_valid_d = 1'b1;
                hold_byte_d  = rx_byte_s;
            end else begin
                err_d[ERR_OVERRUN] = 1'b1;
            end
        end else if (consume_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (rx_frame_err_s) begin
            err_d[ERR_FRAME] = 1'b1;
        end else begin
            err_d[ERR_FRAME] = err_d[ERR_FRAME];
        end

        case (state_q)
            P_IDLE: begin
                if (consume_s) begin
                    if (ch_s == CH_AT) begin
                        state_d = P_ADDR;
                        acc_d   = '0;
                        dcnt_d  = '0;
                    end else if (is_hex(ch_s)) begin
                        state_d = P_DATA;
                        data_d  = {4'h0, hex_val(ch_s)};
                        dcnt_d  = CNT_W'(1);
                        skip_d  = 1'b0;
                    end else if (ch_s == CH_SLASH) begin
                        state_d = P_SLASH;
                    end else if (is_space(ch_s)) begin
                        state_d = P_IDLE;
                    end else begin
                        err_d[ERR_SYNTAX] = 1'b1;
                    end
                end else begin
                    state_d = P_IDLE;
                end
            end
            P_ADDR: begin
                if (consume_s) begin
                    if (is_hex(ch_s)) begin
                        acc_d = {acc_q[ADDR_WIDTH-5:0], hex_val(ch_s)};
                        // Saturate one past the limit so overlong tokens stay flagged.
                        if (dcnt_q <= MAX_DIG) begin
                            dcnt_d = dcnt_q + CNT_W'(1);
                        end else begin
                            dcnt_d = dcnt_q;
                        end
                    end else if (is_space(ch_s)) begin
                        state_d = P_IDLE;
                        if ((dcnt_q == '0) || (dcnt_q > MAX_DIG)) begin
                            err_d[ERR_SYNTAX] = 1'b1;
                        end else begin
                            addr_d = acc_q;
                        end
                    end else begin
                        err_d[ERR_SYNTAX] = 1'b1;
                        state_d           = P_IDLE;
                    end
                end else begin
                    state_d = P_ADDR;
                end
            end
            P_DATA: begin
                if (consume_s) begin
                    if (is_hex(ch_s)) begin
                        if (skip_q) begin
                            skip_d = 1'b1;
                        end else if (dcnt_q == CNT_W'(2)) begin
                            err_d[ERR_SYNTAX] = 1'b1;
                            skip_d            = 1'b1;
                        end else begin
                            data_d = {data_q[3:0], hex_val(ch_s)};
                            dcnt_d = dcnt_q + CNT_W'(1);
                        end
                    end else if (is_space(ch_s)) begin
                        if (skip_q) begin
                            state_d = P_IDLE;
                        end else begin
                            state_d = P_EMIT;
                        end
                    end else begin
                        err_d[ERR_SYNTAX] = 1'b1;
                        state_d           = P_IDLE;
                    end
                end else begin
                    state_d = P_DATA;
                end
            end
            P_SLASH: begin
                if (consume_s) begin
                    if (ch_s == CH_SLASH) begin
                        state_d = P_COMMENT;
                    end else begin
                        err_d[ERR_SYNTAX] = 1'b1;
                        state_d           = P_IDLE;
                    end
                end else begin
                    state_d = P_SLASH;
                end
            end
            P_COMMENT: begin
                if (consume_s && (ch_s == CH_LF)) begin
                    state_d = P_IDLE;
                end else begin
                    state_d = P_COMMENT;
                end
            end
            P_EMIT: begin
                if (wr_ready) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = P_IDLE;
                end else begin
                    state_d = P_EMIT;
                end
            end
            default: begin
                state_d = P_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mfp_uart_hex_loader.sv
// Directed bench for the UART hex loader: serialises ASCII text onto UART_RX
// (16 clocks per bit) and checks the write requests and error flags.
module tb_mfp_uart_hex_loader;

    logic        SI_ClkIn;
    logic        SI_Reset;
    logic        UART_RX;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        busy;
    logic [2:0]  error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cap_addr[$];
    logic [7:0]  cap_byte[$];

    mfp_uart_hex_loader #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .ADDR_WIDTH (32)
    ) dut (
        .SI_ClkIn (SI_ClkIn),
        .SI_Reset (SI_Reset),
        .UART_RX  (UART_RX),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_byte  (wr_byte),
        .busy     (busy),
        .error    (error)
    );

    initial SI_ClkIn = 1'b0;
    always #5 SI_ClkIn = ~SI_ClkIn;

    // Record every accepted write request (inputs change just after posedge).
    always @(negedge SI_ClkIn) begin
        if (!SI_Reset && wr_valid && wr_ready) begin
            cap_addr.push_back(wr_addr);
            cap_byte.push_back(wr_byte);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SI_ClkIn);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_cap(input int idx, input logic [31:0] a, input logic [7:0] b);
        logic [31:0] oa;
        logic [31:0] ob;
        if (idx < cap_addr.size()) begin
            oa = cap_addr[idx];
            ob = {24'h0, cap_byte[idx]};
        end else begin
            oa = 32'hxxxx_xxxx;
            ob = 32'hxxxx_xxxx;
        end
        check($sformatf("req%0d_addr", idx), oa, a);
        check($sformatf("req%0d_byte", idx), ob, {24'h0, b});
    endtask

    task automatic do_reset();
        SI_Reset = 1'b1;
        tick(3);
        SI_Reset = 1'b0;
        cap_addr.delete();
        cap_byte.delete();
        tick(2);
    endtask

    task automatic send_char(input logic [7:0] c, input logic bad_stop);
        UART_RX = 1'b0;
        tick(16);
        for (int b = 0; b < 8; b++) begin
            UART_RX = c[b];
            tick(16);
        end
        UART_RX = ~bad_stop;
        tick(16);
        UART_RX = 1'b1;
        tick(4);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i], 1'b0);
        end
        tick(10);
    endtask

    initial begin
        SI_Reset = 1'b1;
        UART_RX  = 1'b1;
        wr_ready = 1'b1;
        do_reset();

        // Reset values
        @(negedge SI_ClkIn);
        check("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        check("rst_wr_addr", wr_addr, 32'h0);
        check("rst_wr_byte", {24'h0, wr_byte}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_error", {29'h0, error}, 32'h0);

        // Address load and two data bytes
        send_str("@00000010\n3c 08\n");
        check("t1_count", cap_addr.size(), 32'd2);
        check_cap(0, 32'h0000_0010, 8'h3C);
        check_cap(1, 32'h0000_0011, 8'h08);
        check("t1_error", {29'h0, error}, 32'h0);

        // Address wraps from all-ones to zero
        do_reset();
        send_str("@FFFFFFFF\nAA BB\n");
        check("t2_count", cap_addr.size(), 32'd2);
        check_cap(0, 32'hFFFF_FFFF, 8'hAA);
        check_cap(1, 32'h0000_0000, 8'hBB);
        check("t2_error", {29'h0, error}, 32'h0);

        // Comment is skipped silently
        do_reset();
        send_str("12 // x@zz\n34\n");
        check("t3_count", cap_addr.size(), 32'd2);
        check_cap(0, 32'h0, 8'h12);
        check_cap(1, 32'h1, 8'h34);
        check("t3_error", {29'h0, error}, 32'h0);

        // Syntax errors: three-digit byte and empty address
        do_reset();
        send_str("123\n");
        check("t4_count_a", cap_addr.size(), 32'd0);
        check("t4_error_a", {29'h0, error}, 32'h2);
        send_str("@\n");
        check("t4_count_b", cap_addr.size(), 32'd0);
        send_str("5a\n");
        check("t4_count_c", cap_addr.size(), 32'd1);
        check_cap(0, 32'h0, 8'h5A);
        check("t4_error", {29'h0, error}, 32'h2);

        // Framing error drops the character; loading continues
        do_reset();
        send_char(8'h37, 1'b1);
        tick(10);
        check("t5_count_a", cap_addr.size(), 32'd0);
        check("t5_error_a", {29'h0, error}, 32'h1);
        send_str("1\n");
        check("t5_count_b", cap_addr.size(), 32'd1);
        check_cap(0, 32'h0, 8'h01);

        // Short low glitch on an idle line is ignored
        do_reset();
        UART_RX = 1'b0;
        tick(3);
        UART_RX = 1'b1;
        tick(40);
        @(negedge SI_ClkIn);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_error", {29'h0, error}, 32'h0);
        send_str("2\n");
        check("t6_count", cap_addr.size(), 32'd1);
        check_cap(0, 32'h0, 8'h02);

        // Consumer stalls for several character times -> overrun
        do_reset();
        wr_ready = 1'b0;
        send_str("01 02 ");
        wr_ready = 1'b1;
        send_str("03 04\n");
        check_cap(0, 32'h0, 8'h01);
        check("t7_overrun", {29'h0, (error & 3'b100)}, 32'h4);

        // Reset in the middle of a character clears everything next cycle
        UART_RX = 1'b0;
        tick(40);
        @(negedge SI_ClkIn);
        check("t8_busy_mid", {31'h0, busy}, 32'h1);
        @(posedge SI_ClkIn);
        #1;
        SI_Reset = 1'b1;
        UART_RX  = 1'b1;
        @(posedge SI_ClkIn);
        @(negedge SI_ClkIn);
        check("t8_wr_valid", {31'h0, wr_valid}, 32'h0);
        check("t8_wr_addr", wr_addr, 32'h0);
        check("t8_wr_byte", {24'h0, wr_byte}, 32'h0);
        check("t8_busy", {31'h0, busy}, 32'h0);
        check("t8_error", {29'h0, error}, 32'h0);
        @(posedge SI_ClkIn);
        #1;
        SI_Reset = 1'b0;
        cap_addr.delete();
        cap_byte.delete();
        tick(20);
        send_str("77\n");
        check("t8_count", cap_addr.size(), 32'd1);
        check_cap(0, 32'h0, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
